// File: rtl/fifo_wr_arbiter_if.sv
// rtl/fifo_wr_arbiter_if.sv - requester/FIFO-write bundle seen by the round-robin write arbiter
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
);

  // requester side
  logic [NUM_REQ-1:0]            req_valid_i;
  logic [NUM_REQ-1:0]            req_ready_o;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data_i;

  // FIFO write-port side
  logic                  out_valid_o;
  logic                  out_ready_i;
  logic [DATA_WIDTH-1:0] out_data_o;
  logic [ID_WIDTH-1:0]   out_id_o;
  logic                  fifo_afull_i;

  // status
  logic [NUM_REQ-1:0] grant_o;
  logic               busy_o;

  // arbiter view
  modport slave (
    input  req_valid_i, req_data_i, out_ready_i, fifo_afull_i,
    output req_ready_o, out_valid_o, out_data_o, out_id_o, grant_o, busy_o
  );

  // requesters + FIFO view
  modport master (
    output req_valid_i, req_data_i, out_ready_i, fifo_afull_i,
    input  req_ready_o, out_valid_o, out_data_o, out_id_o, grant_o, busy_o
  );

endinterface

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 4,
  parameter int MAX_BURST  = 4
) (
  input logic              clk,
  input logic              rst_n,
  fifo_wr_arbiter_if.slave bus
);

  localparam int ID_WIDTH  = $clog2(NUM_REQ);
  localparam int CNT_WIDTH = $clog2(MAX_BURST + 1);

  localparam logic [CNT_WIDTH-1:0] LAST_BEAT = CNT_WIDTH'(MAX_BURST - 1);
  localparam logic [ID_WIDTH-1:0]  LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  state_t               state;
  logic [ID_WIDTH-1:0]  g;
  logic [ID_WIDTH-1:0]  last_id;
  logic [CNT_WIDTH-1:0] beat_cnt;

  logic                  arb_found;
  logic [ID_WIDTH-1:0]   arb_idx;
  logic                  cur_valid;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  beat;
  logic                  release_now;
  logic                  take_grant;

  // Requester index k steps past base+1, wrapping at NUM_REQ (also for non-power-of-2 counts).
  function automatic logic [ID_WIDTH-1:0] rr_pos(input logic [ID_WIDTH-1:0] base, input int k);
    int p;
    p = int'(base) + 1 + k;
    if (p >= NUM_REQ) begin
      p = p - NUM_REQ;
    end
    return p[ID_WIDTH-1:0];
  endfunction

  // One-hot vector with only bit idx set.
  function automatic logic [NUM_REQ-1:0] one_hot(input logic [ID_WIDTH-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (idx == ID_WIDTH'(i)) begin
        v[i] = 1'b1;
      end
    end
    return v;
  endfunction

  // Round-robin search starting just after last_id; scanning from the far end lets the nearest
  // valid requester overwrite, so last_id itself ends up with the lowest priority.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid_i[rr_pos(last_id, k)]) begin
        arb_found = 1'b1;
        arb_idx   = rr_pos(last_id, k);
      end
    end
  end

  // Select the granted requester's valid and data lane.
  always_comb begin
    cur_valid = 1'b0;
    cur_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (g == ID_WIDTH'(i)) begin
        cur_valid = bus.req_valid_i[i];
        cur_data  = bus.req_data_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // A burst ends on its last beat or as soon as the owner stops presenting valid; either way
  // a waiting requester is granted on the same edge so there is no idle bubble.
  assign beat        = (state == BUSY) && cur_valid && bus.out_ready_i;
  assign release_now = (state == BUSY) && (!cur_valid || (beat && (beat_cnt == LAST_BEAT)));
  assign take_grant  = ((state == IDLE) || release_now) && arb_found && !bus.fifo_afull_i;

  // Pure mux from the granted requester to the FIFO write port; everything is zero while idle.
  always_comb begin
    bus.out_valid_o = 1'b0;
    bus.out_data_o  = '0;
    bus.out_id_o    = '0;
    bus.req_ready_o = '0;
    if (state == BUSY) begin
      bus.out_valid_o    = cur_valid;
      bus.out_data_o     = cur_data;
      bus.out_id_o       = g;
      bus.req_ready_o[g] = bus.out_ready_i;
    end
  end

  // Grant FSM: holds the grant index, round-robin pointer, burst counter and registered status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      g           <= '0;
      last_id     <= LAST_REQ;
      beat_cnt    <= '0;
      bus.grant_o <= '0;
      bus.busy_o  <= 1'b0;
    end else if (take_grant) begin
      state       <= BUSY;
      g           <= arb_idx;
      last_id     <= arb_idx;
      beat_cnt    <= '0;
      bus.grant_o <= one_hot(arb_idx);
      bus.busy_o  <= 1'b1;
    end else if (release_now) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      bus.grant_o <= '0;
      bus.busy_o  <= 1'b0;
    end else if (beat) begin
      beat_cnt <= beat_cnt + CNT_WIDTH'(1);
    end
  end

  // Structural invariants of the grant state.
  a_grant_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.grant_o));
  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(bus.req_ready_o));
  a_cnt_bound    : assert property (@(posedge clk) disable iff (!rst_n) beat_cnt <= LAST_BEAT);
  a_busy_state   : assert property (@(posedge clk) disable iff (!rst_n) bus.busy_o == (state == BUSY));

endmodule
